bcd_to_binary_seq: RTL
======================

// Module: bcd_to_binary_seq
// PURPOSE
//  Sequential BCD-to-binary converter: reverse double-dabble, one bit per clock.
//  Takes a packed DIGITS-digit BCD word and returns an unsigned BIN_W-bit binary value.
//  Partner block to the combinational binary-to-BCD path; used to turn keypad/display
//  digits back into binary operands.
// PARAMETERS
//  DIGITS  3  number of BCD digits in BCD_IN (>=1)
//  BIN_W   8  binary result width, equal to the iteration count (>=1)
// PORTS
//  clk      in   1          rising-edge clock
//  rst_n    in   1          async active-low reset
//  start    in   1          request; accepted only in IDLE or DONE
//  BCD_IN   in   4*DIGITS   packed BCD, digit 0 (ones) = [3:0]; sampled on accept
//  busy     out  1          high while in CHECK or SHIFT
//  done     out  1          one-cycle pulse when the result is valid
//  BIN_OUT  out  BIN_W      result; held stable until the next accept
//  ovf      out  1          value >= 2**BIN_W; held with BIN_OUT
//  err      out  1          some input nibble > 9; held with BIN_OUT
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; busy=0, done=0, BIN_OUT=0, ovf=0, err=0.
//   All internal registers clear.
//  FSM states: IDLE, CHECK, SHIFT, DONE.
//  IDLE/DONE, start=1:
//   - bcd_r <= BCD_IN, bin_r <= 0, cnt <= 0.
//   - Clear ovf and err. Go to CHECK.
//   - BIN_OUT keeps its old value until DONE.
//  CHECK (1 cycle):
//   - Any nibble of bcd_r > 9: err <= 1, BIN_OUT <= 0, ovf <= 0, go to DONE.
//   - Otherwise go to SHIFT.
//  SHIFT (BIN_W cycles), each cycle:
//   - {bcd_r, bin_r} <= {bcd_r, bin_r} >> 1.
//   - Then every shifted digit that is >= 8 has 3 subtracted (4-bit, no borrow).
//   - Do both steps combinationally in the same cycle.
//   - cnt increments. After the cycle where cnt == BIN_W-1, go to DONE.
//  DONE entry:
//   - done pulses for exactly 1 cycle.
//   - BIN_OUT <= bin_r.
//   - ovf <= (bcd_r != 0), i.e. residual digits remain after BIN_W shifts.
//  Latency: done is 1 + BIN_W + 1 cycles after the accepting edge (10 for BIN_W=8).
//   The err path takes 2 cycles.
//  start while busy: ignored. No queueing, no restart.
//  start in DONE: accepted; back-to-back conversions give 1 result per BIN_W+2 cycles.
//  DONE with no start returns to IDLE next cycle. Outputs are held.
//  BCD_IN may change freely after the accept edge.
//  Reset mid-conversion aborts immediately. No done pulse. Outputs go to reset values.
//  Counter width is $clog2(BIN_W+1). No combinational path from inputs to outputs.
// CONFIGURATION
//  BCD_SAT_EN defined:
//   - On overflow, BIN_OUT = {BIN_W{1'b1}}; ovf is still flagged.
//  BCD_SAT_EN undefined:
//   - On overflow, BIN_OUT = value mod 2**BIN_W (raw bin_r); ovf is still flagged.
//  err behaviour is the same in both builds.
// TESTING (DIGITS=3, BIN_W=8 unless noted)
//  1. BCD_IN=12'h255, start -> done at +10 cycles, BIN_OUT=8'hFF, ovf=0, err=0.
//   Also sweep all 0..999 against a reference model.
//  2. BCD_IN=12'h256 -> ovf=1. BIN_OUT=8'h00 without BCD_SAT_EN, 8'hFF with it.
//   12'h999 -> ovf=1, BIN_OUT=8'hE7 without the macro.
//  3. BCD_IN=12'h0A5 -> done at +2 cycles, err=1, BIN_OUT=0, ovf=0.
//   12'h000 -> BIN_OUT=0, no flags.
//  4. Pulse start again while busy with a different value -> ignored, first result returned.
//   Then start in the DONE cycle -> second result 10 cycles later.
//  5. Assert rst_n=0 at cycle 5 of SHIFT -> busy=0, no done, BIN_OUT=0.
//   A new conversion after release is correct.
//  6. DIGITS=4, BIN_W=14, BCD_IN=16'h9999 -> BIN_OUT=14'd9999, ovf=0, done at +16 cycles.

Source files
------------

// File: rtl/bcd_to_binary_seq.sv
// -----------------------------------------------------------------------------
// bcd_to_binary_seq
// Sequential BCD-to-binary converter using reverse double-dabble, one result
// bit per clock. A packed DIGITS-digit BCD word is converted to an unsigned
// BIN_W-bit value in BIN_W shift cycles, bracketed by one CHECK cycle that
// rejects illegal nibbles and one DONE cycle that publishes the result.
//
// Handshake: start is sampled on a rising edge and is taken only in IDLE or
// DONE. BCD_IN is captured on that same edge and may change freely afterwards.
// done is a one-cycle pulse. BIN_OUT, ovf and err are held stable from that
// pulse until the next accepted start. A start while busy is dropped.
//
// Timing: the accepting edge moves the FSM to CHECK, and the next edge moves
// it to SHIFT. Shifts happen on the following BIN_W edges. The last shift
// edge also loads the result and raises done. A downstream register therefore
// captures done on the BIN_W+2'th edge after the accept. On the err path it
// captures done on the 2nd edge.
//
// Configuration macro: BCD_SAT_EN
//   defined   : on overflow BIN_OUT saturates to all ones (ovf still set)
//   undefined : on overflow BIN_OUT is the value modulo 2**BIN_W (ovf set)
// -----------------------------------------------------------------------------
module bcd_to_binary_seq #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   BCD_IN,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      BIN_OUT,
    output logic                  ovf,
    output logic                  err
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int TOT_W = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state;
    logic [BCD_W-1:0]   bcd_r;
    logic [BIN_W-1:0]   bin_r;
    logic [CNT_W-1:0]   cnt;

    // Combinational next-step values for one shift cycle
    logic [TOT_W-1:0]   shifted;
    logic [BCD_W-1:0]   sh_bcd;
    logic [BCD_W-1:0]   adj_bcd;
    logic [BIN_W-1:0]   sh_bin;

    // Result that would be published if this shift cycle is the last one
    logic               res_ovf;
    logic [BIN_W-1:0]   res_bin;

    // Illegal-digit detection on the captured word
    logic               nib_err;

    // One reverse double-dabble step: halve the whole BCD:binary word, then
    // correct every digit that received a carried-in 8 (10/2 = 5 = 8-3).
    always_comb begin
        shifted = {bcd_r, bin_r} >> 1;
        sh_bin  = shifted[BIN_W-1:0];
        sh_bcd  = shifted[TOT_W-1:BIN_W];
        adj_bcd = sh_bcd;
        for (int d = 0; d < DIGITS; d++) begin
            if (sh_bcd[4*d +: 4] >= 4'd8) begin
                adj_bcd[4*d +: 4] = sh_bcd[4*d +: 4] - 4'd3;
            end
        end
    end

    // Residual digits after the final shift mean the value did not fit.
    always_comb begin
        res_ovf = (adj_bcd != '0);
`ifdef BCD_SAT_EN
        res_bin = res_ovf ? {BIN_W{1'b1}} : sh_bin;
`else
        res_bin = sh_bin;
`endif
    end

    // Flag any captured nibble outside 0..9
    always_comb begin
        nib_err = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd_r[4*d +: 4] > 4'd9) begin
                nib_err = 1'b1;
            end
        end
    end

    // Control FSM with all outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            bcd_r   <= '0;
            bin_r   <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            BIN_OUT <= '0;
            ovf     <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        bcd_r <= BCD_IN;
                        bin_r <= '0;
                        cnt   <= '0;
                        ovf   <= 1'b0;
                        err   <= 1'b0;
                        busy  <= 1'b1;
                        state <= CHECK;
                    end else begin
                        state <= IDLE;
                    end
                end
                CHECK: begin
                    if (nib_err) begin
                        err     <= 1'b1;
                        ovf     <= 1'b0;
                        BIN_OUT <= '0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end else begin
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd_r <= adj_bcd;
                    bin_r <= sh_bin;
                    cnt   <= cnt + CNT_ONE;
                    if (cnt == CNT_LAST) begin
                        BIN_OUT <= res_bin;
                        ovf     <= res_ovf;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
